// File: rtl/pe_conv_controller.sv
// Sequences one processing element through a 3x3 convolution as three
// kernel-row passes: load the row weight, stream image/psum reads, and
// retire PE results into the psum BRAM through a fixed-latency write pipe.
module pe_conv_controller #(
    parameter int OUT_W  = 4,
    parameter int OUT_H  = 3,
    parameter int PE_LAT = 2,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [4:0]        exp_bias_cfg,
    output logic              busy,
    output logic              done,
    output logic [4:0]        exp_bias,
    output logic              wgt_en,
    output logic [1:0]        wgt_addr,
    output logic              img_en,
    output logic [ADDR_W-1:0] img_addr,
    output logic              psum_ren,
    output logic [ADDR_W-1:0] psum_raddr,
    output logic              psum_zero,
    output logic              psum_we,
    output logic [ADDR_W-1:0] psum_waddr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WLOAD,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    // Write pipe depth: one BRAM read cycle plus the PE latency.
    localparam int DL = 1 + PE_LAT;
    localparam int CW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int RW = (OUT_H > 1) ? $clog2(OUT_H) : 1;
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(OUT_W);
    localparam logic [CW-1:0] COL_LAST = CW'(OUT_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(OUT_H - 1);
    // Every pipe stage except the one being written this cycle.
    localparam logic [DL-1:0] PEND_MASK = {DL{1'b1}} >> 1;

    state_t            state_reg, state_next;
    logic [1:0]        k_reg;
    logic [CW-1:0]     ocol_reg;
    logic [RW-1:0]     orow_reg;
    logic [ADDR_W-1:0] img_base_reg;
    logic [ADDR_W-1:0] psum_base_reg;
    logic [ADDR_W-1:0] kbase_reg;
    logic [4:0]        exp_bias_reg;
    logic              zero_reg;
    logic [DL-1:0]     dl_v_reg;
    logic [ADDR_W-1:0] dl_a_reg [DL];

    logic              accept;
    logic              issue;
    logic              last_issue;
    logic              drain_done;
    logic              next_pass;
    logic [ADDR_W-1:0] issue_raddr;

    assign accept      = (state_reg == S_IDLE) && start;
    assign issue       = (state_reg == S_RUN);
    assign last_issue  = issue && (ocol_reg == COL_LAST) && (orow_reg == ROW_LAST);
    assign drain_done  = (dl_v_reg & PEND_MASK) == '0;
    assign next_pass   = (state_reg == S_DRAIN) && drain_done && (k_reg != 2'd2);
    assign issue_raddr = psum_base_reg + ADDR_W'(ocol_reg);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= S_IDLE;
        else     state_reg <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (start) state_next = S_WLOAD;
            S_WLOAD: state_next = S_RUN;
            S_RUN:   if (last_issue) state_next = S_DRAIN;
            S_DRAIN: if (drain_done) state_next = (k_reg == 2'd2) ? S_DONE : S_WLOAD;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Pass/row/column counters and incremental address bases (no multiplier).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_reg         <= '0;
            ocol_reg      <= '0;
            orow_reg      <= '0;
            img_base_reg  <= '0;
            psum_base_reg <= '0;
            kbase_reg     <= '0;
            exp_bias_reg  <= '0;
        end else if (accept) begin
            k_reg         <= '0;
            ocol_reg      <= '0;
            orow_reg      <= '0;
            img_base_reg  <= '0;
            psum_base_reg <= '0;
            kbase_reg     <= '0;
            exp_bias_reg  <= exp_bias_cfg;
        end else if (issue) begin
            if (ocol_reg == COL_LAST) begin
                ocol_reg      <= '0;
                orow_reg      <= orow_reg + 1'b1;
                img_base_reg  <= img_base_reg + ROW_STEP;
                psum_base_reg <= psum_base_reg + ROW_STEP;
            end else begin
                ocol_reg <= ocol_reg + 1'b1;
            end
        end else if (next_pass) begin
            k_reg         <= k_reg + 1'b1;
            ocol_reg      <= '0;
            orow_reg      <= '0;
            psum_base_reg <= '0;
            kbase_reg     <= kbase_reg + ROW_STEP;
            img_base_reg  <= kbase_reg + ROW_STEP;
        end
    end

    // Zero-psum flag lines up with BRAM data, one cycle after the pass-0 issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) zero_reg <= 1'b0;
        else     zero_reg <= issue && (k_reg == 2'd0);
    end

    // Write pipe stage 0 captures the issue; address is zero when no issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dl_v_reg[0] <= 1'b0;
            dl_a_reg[0] <= '0;
        end else begin
            dl_v_reg[0] <= issue;
            dl_a_reg[0] <= issue ? issue_raddr : '0;
        end
    end

    generate
        for (genvar gi = 1; gi < DL; gi++) begin : g_dl
            // Write pipe stage gi shifts the previous stage forward.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dl_v_reg[gi] <= 1'b0;
                    dl_a_reg[gi] <= '0;
                end else begin
                    dl_v_reg[gi] <= dl_v_reg[gi-1];
                    dl_a_reg[gi] <= dl_a_reg[gi-1];
                end
            end
        end
    endgenerate

    // Outputs decoded from state; addresses are zero outside their enables.
    always_comb begin
        busy       = (state_reg != S_IDLE);
        done       = (state_reg == S_DONE);
        exp_bias   = exp_bias_reg;
        wgt_en     = (state_reg == S_WLOAD);
        wgt_addr   = wgt_en ? k_reg : 2'd0;
        img_en     = issue;
        img_addr   = issue ? (img_base_reg + ADDR_W'(ocol_reg)) : '0;
        psum_ren   = issue;
        psum_raddr = issue ? issue_raddr : '0;
        psum_zero  = zero_reg;
        psum_we    = dl_v_reg[DL-1];
        psum_waddr = dl_a_reg[DL-1];
    end

endmodule

// File: tb/tb_pe_conv_controller.sv
// Directed bench for pe_conv_controller (OUT_W=4, OUT_H=3, PE_LAT=2).
module tb_pe_conv_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [4:0] exp_bias_cfg;
    logic       busy, done, wgt_en, img_en, psum_ren, psum_zero, psum_we;
    logic [4:0] exp_bias;
    logic [1:0] wgt_addr;
    logic [9:0] img_addr, psum_raddr, psum_waddr;

    int checks = 0;
    int errors = 0;

    pe_conv_controller #(.OUT_W(4), .OUT_H(3), .PE_LAT(2), .ADDR_W(10)) dut (
        .clk(clk), .rst(rst), .start(start), .exp_bias_cfg(exp_bias_cfg),
        .busy(busy), .done(done), .exp_bias(exp_bias),
        .wgt_en(wgt_en), .wgt_addr(wgt_addr),
        .img_en(img_en), .img_addr(img_addr),
        .psum_ren(psum_ren), .psum_raddr(psum_raddr), .psum_zero(psum_zero),
        .psum_we(psum_we), .psum_waddr(psum_waddr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag, input int cyc);
        chk({tag, "_busy"}, cyc, 32'(busy), 0);
        chk({tag, "_done"}, cyc, 32'(done), 0);
        chk({tag, "_expb"}, cyc, 32'(exp_bias), 0);
        chk({tag, "_wgt"},  cyc, {wgt_en, wgt_addr}, 0);
        chk({tag, "_img"},  cyc, {img_en, img_addr}, 0);
        chk({tag, "_prd"},  cyc, {psum_ren, psum_raddr, psum_zero}, 0);
        chk({tag, "_pwr"},  cyc, {psum_we, psum_waddr}, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Spec-derived run window: issue index within a pass, -1 outside RUN.
    function automatic int run_idx(input int c);
        if (c < 2 || c > 45) return -1;
        if (((c - 2) % 16) >= 12) return -1;
        return (c - 2) % 16;
    endfunction

    initial begin
        int wr_pass [12];
        int we_cnt, done_cnt, rd_pass, idx, widx, done_cyc;

        rst = 1'b1;
        start = 1'b0;
        exp_bias_cfg = 5'b00100;
        step();
        step();
        chk_zero("reset", -1);
        rst = 1'b0;

        // ---- Full layer with start re-pulses and a cfg change mid-layer ----
        foreach (wr_pass[i]) wr_pass[i] = -1;
        we_cnt = 0;
        done_cnt = 0;
        rd_pass = -1;
        for (int c = 0; c <= 55; c++) begin
            start = (c == 0 || c == 10 || c == 49);
            if (c == 5) exp_bias_cfg = 5'b11011;
            idx  = run_idx(c);
            widx = run_idx(c - 3);
            chk("busy", c, 32'(busy), 32'(c >= 1 && c <= 49));
            chk("done", c, 32'(done), 32'(c == 49));
            chk("wgt_en", c, 32'(wgt_en), 32'(c == 1 || c == 17 || c == 33));
            chk("wgt_addr", c, 32'(wgt_addr), (c == 1 || c == 17 || c == 33) ? (c - 1) / 16 : 0);
            chk("img_en", c, 32'(img_en), 32'(idx >= 0));
            chk("psum_ren", c, 32'(psum_ren), 32'(idx >= 0));
            chk("img_addr", c, 32'(img_addr), (idx >= 0) ? idx + 4 * ((c - 2) / 16) : 0);
            chk("psum_raddr", c, 32'(psum_raddr), (idx >= 0) ? idx : 0);
            chk("psum_zero", c, 32'(psum_zero), 32'(c >= 3 && c <= 14));
            chk("psum_we", c, 32'(psum_we), 32'(widx >= 0));
            chk("psum_waddr", c, 32'(psum_waddr), (widx >= 0) ? widx : 0);
            if (c >= 1 && c <= 55) chk("exp_bias", c, 32'(exp_bias), 5'b00100);
            if (wgt_en) rd_pass++;
            // Read of addr a in pass p>0 must follow its pass p-1 write.
            if (psum_ren && rd_pass > 0 && psum_raddr < 12)
                chk("raw_order", c, 32'(wr_pass[psum_raddr] >= rd_pass - 1), 1);
            if (psum_we) begin
                if (psum_waddr < 12) wr_pass[psum_waddr] = we_cnt / 12;
                we_cnt++;
            end
            if (done) done_cnt++;
            step();
        end
        start = 1'b0;
        chk("we_total", 56, we_cnt, 36);
        chk("done_total", 56, done_cnt, 1);

        // ---- Reset mid pass 1, then a fresh layer from cycle 25 ----
        we_cnt = 0;
        done_cnt = 0;
        done_cyc = -1;
        for (int c = 0; c <= 80; c++) begin
            start = (c == 0 || c == 25);
            if (c == 0) exp_bias_cfg = 5'b00100;
            if (c == 25) exp_bias_cfg = 5'b11011;
            if (c == 20) begin
                rst = 1'b1;
                #1;
                chk_zero("midrst", c);
            end
            if (c == 21) rst = 1'b0;
            if (c >= 21 && c <= 24) begin
                chk("post_rst_we", c, 32'(psum_we), 0);
                chk("post_rst_busy", c, 32'(busy), 0);
            end
            if (c == 30) chk("exp_bias2", c, 32'(exp_bias), 5'b11011);
            chk("busy2", c, 32'(busy), 32'((c >= 1 && c <= 19) || (c >= 26 && c <= 74)));
            if (psum_we && c > 20) we_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = c;
            end
            step();
        end
        start = 1'b0;
        chk("done_cycle2", 81, done_cyc, 74);
        chk("done_total2", 81, done_cnt, 1);
        chk("we_total2", 81, we_cnt, 36);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
